// File: rtl/bram_stream_reader.sv
// Read-side streamer for a single-port BRAM: walks an address range, absorbs the
// one-cycle read latency and presents the words as a valid/ready stream.
module bram_stream_reader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic                  bram_wr,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [DATA_WIDTH-1:0] bram_rdata,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready
);

    localparam int unsigned CNT_W      = ADDR_WIDTH + 1;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned PTR_W      = 2;
    localparam int unsigned OCC_W      = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      len_q, len_d;
    logic [CNT_W-1:0]      issued_q, issued_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic                  v1_q, v2_q, l1_q, l2_q;
    logic                  issue, issue_last;
    logic                  push, pop, credit_ok;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic [PTR_W-1:0]      rd_q, rd_d, wr_q, wr_d;
    logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_last;
    logic [DATA_WIDTH-1:0] head_data, data_d;
    logic                  head_last;
    logic                  busy_d, done_d, valid_d, last_d;

    assign bram_wr = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state, read issue and the registered view of the FIFO head.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        issued_d   = issued_q;
        addr_d     = bram_addr;
        issue      = 1'b0;
        issue_last = 1'b0;
        done_d     = 1'b0;

        pop       = m_valid && m_ready;
        push      = v2_q;
        credit_ok = (occ_q + OCC_W'(v1_q) + OCC_W'(v2_q)) < OCC_W'(FIFO_DEPTH);

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        // The accepting edge also issues the first read.
                        state_d    = RUN;
                        len_d      = length;
                        issued_d   = CNT_W'(1);
                        addr_d     = start_addr;
                        issue      = 1'b1;
                        issue_last = (length == CNT_W'(1));
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if ((issued_q < len_q) && credit_ok) begin
                    issue      = 1'b1;
                    issue_last = (issued_q == CNT_W'(len_q - CNT_W'(1)));
                    issued_d   = CNT_W'(issued_q + CNT_W'(1));
                    addr_d     = ADDR_WIDTH'(bram_addr + ADDR_WIDTH'(1));
                end
                if (pop && m_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        occ_d = OCC_W'(occ_q + OCC_W'(push) - OCC_W'(pop));
        rd_d  = PTR_W'(rd_q + PTR_W'(pop));
        wr_d  = PTR_W'(wr_q + PTR_W'(push));

        // A push lands on the new head only when the FIFO drains to empty this cycle.
        if (push && (wr_q == rd_d)) begin
            head_data = bram_rdata;
            head_last = l2_q;
        end else begin
            head_data = mem_data[rd_d];
            head_last = mem_last[rd_d];
        end

        valid_d = (occ_d != '0);
        data_d  = valid_d ? head_data : '0;
        last_d  = valid_d && head_last;
        busy_d  = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q     <= '0;
            issued_q  <= '0;
            bram_addr <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            l1_q      <= 1'b0;
            l2_q      <= 1'b0;
            occ_q     <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            mem_last  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_data[i] <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            m_data    <= '0;
        end else begin
            len_q     <= len_d;
            issued_q  <= issued_d;
            bram_addr <= addr_d;
            v1_q      <= issue;
            v2_q      <= v1_q;
            l1_q      <= issue_last;
            l2_q      <= l1_q;
            occ_q     <= occ_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            if (push) begin
                mem_data[wr_q] <= bram_rdata;
                mem_last[wr_q] <= l2_q;
            end
            busy      <= busy_d;
            done      <= done_d;
            m_valid   <= valid_d;
            m_last    <= last_d;
            m_data    <= data_d;
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed and randomized bench for bram_stream_reader with a behavioural RAM and
// a queue-based model of the expected beat sequence.
module tb_bram_stream_reader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  start_addr;
    logic [4:0]  length;
    logic        busy;
    logic        done;
    logic        bram_wr;
    logic [3:0]  bram_addr;
    logic [31:0] bram_rdata;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready;

    logic [31:0] ram [16];
    int          total = 0;
    int          bad   = 0;

    bram_stream_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .bram_wr    (bram_wr),
        .bram_addr  (bram_addr),
        .bram_rdata (bram_rdata),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_last     (m_last),
        .m_ready    (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM: data for an address appears one cycle later.
    always @(posedge clk) bram_rdata <= ram[bram_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ready_for(input int mode, input int c);
        if (mode == 1) return 1'($urandom_range(0, 1));
        if (mode == 2) begin
            if (c < 4) return 1'b1;
            if (c <= 10) return 1'b0;
            return 1'((c - 11) % 2 == 0);
        end
        return 1'b1;
    endfunction

    task automatic fill_random();
        for (int k = 0; k < 16; k++) ram[k] = $urandom;
    endtask

    // Cycle 0 is the cycle in which start is driven; returns in the done cycle.
    task automatic run_xfer(input logic [3:0] sa, input logic [4:0] len, input int mode,
                            input bit inject);
        logic [31:0] exp_q [$];
        logic [31:0] prev_data;
        logic        prev_last;
        bit          prev_stall;
        bit          seen;
        bit          finished;
        int          idx;
        int          fin;

        for (int k = 0; k < int'(len); k++) exp_q.push_back(ram[4'(int'(sa) + k)]);
        start      = 1'b1;
        start_addr = sa;
        length     = len;
        m_ready    = ready_for(mode, 0);
        idx        = 0;
        fin        = -1;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        seen       = 1'b0;
        finished   = 1'b0;

        for (int c = 1; c <= 300; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            if (inject && c == 2) begin
                start      = 1'b1;
                start_addr = sa ^ 4'd5;
                length     = 5'd3;
            end
            if (inject && c == 3) start = 1'b0;
            m_ready = ready_for(mode, c);
            chk("bram_wr_low", 32'(bram_wr), 32'd0);

            if (len == 5'd0) begin
                chk("zero_done", 32'(done), 32'd1);
                chk("zero_busy", 32'(busy), 32'd0);
                chk("zero_valid", 32'(m_valid), 32'd0);
                finished = 1'b1;
                break;
            end
            if (fin >= 0) begin
                chk("done_pulse", 32'(done), 32'd1);
                chk("busy_after", 32'(busy), 32'd0);
                chk("valid_after", 32'(m_valid), 32'd0);
                finished = 1'b1;
                break;
            end

            chk("done_early", 32'(done), 32'd0);
            chk("busy_run", 32'(busy), 32'd1);
            if (c == 1) chk("first_addr", 32'(bram_addr), 32'(sa));
            if (mode == 2 && c == 10) chk("stall_addr", 32'(bram_addr), 32'(4'(sa + 4'd4)));
            if (prev_stall) begin
                chk("hold_valid", 32'(m_valid), 32'd1);
                chk("hold_data", m_data, prev_data);
                chk("hold_last", 32'(m_last), 32'(prev_last));
            end
            if (mode == 0 && c >= 3 && c <= 2 + int'(len)) chk("no_bubble", 32'(m_valid), 32'd1);

            if (m_valid) begin
                if (!seen) begin
                    chk("first_beat_cycle", 32'(c), 32'd3);
                    seen = 1'b1;
                end
                if (idx < int'(len)) begin
                    chk("beat_data", m_data, exp_q[idx]);
                    chk("beat_last", 32'(m_last), 32'(idx == int'(len) - 1));
                    if (m_ready) begin
                        if (m_last) fin = c;
                        idx++;
                    end
                end else begin
                    chk("extra_beat", 32'(m_valid), 32'd0);
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end

        chk("finished", 32'(finished), 32'd1);
        chk("beat_count", 32'(idx), 32'(len));
        if (mode == 0 && len != 5'd0) chk("final_cycle", 32'(fin), 32'(2 + int'(len)));
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        length     = '0;
        m_ready    = 1'b1;
        for (int k = 0; k < 16; k++) ram[k] = 32'hA000 + 32'(k);

        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_addr", 32'(bram_addr), 32'd0);
        chk("rst_wr", 32'(bram_wr), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_last", 32'(m_last), 32'd0);
        chk("rst_data", m_data, 32'd0);
        rst = 1'b0;
        tick();

        // Basic burst on the incrementing pattern, then back-to-back transfers.
        run_xfer(4'd2, 5'd5, 0, 1'b0);
        fill_random();
        run_xfer(4'd14, 5'd4, 0, 1'b0);
        run_xfer(4'($urandom_range(0, 15)), 5'd16, 0, 1'b0);
        run_xfer(4'($urandom_range(0, 15)), 5'd8, 2, 1'b0);
        run_xfer(4'd7, 5'd0, 0, 1'b0);
        run_xfer(4'($urandom_range(0, 15)), 5'd7, 0, 1'b1);

        for (int r = 0; r < 6; r++) begin
            fill_random();
            run_xfer(4'($urandom_range(0, 15)), 5'($urandom_range(1, 16)), 1, 1'b0);
        end

        // Reset in the middle of a ten-word transfer.
        start      = 1'b1;
        start_addr = 4'd9;
        length     = 5'd10;
        m_ready    = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(m_valid), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_last", 32'(m_last), 32'd0);
        rst = 1'b0;
        run_xfer(4'd3, 5'd6, 0, 1'b0);
        run_xfer(4'($urandom_range(0, 15)), 5'd9, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
